fetch_pc_unit: RTL and testbench

//  PC generator + instruction-fetch front end. Issues word fetches to instruction memory.

---
 rtl/fetch_pc_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// PC generator and instruction-fetch front end: one outstanding imem request, small
// in-order fetch queue toward decode, EX redirect with flush. Optional counters: FETCH_PERF_EN.
module fetch_pc_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_bubble_cnt,
    output logic [15:0]     perf_flush_cnt,
`endif
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    input  logic            if_ready
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_KILL
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            active_q;

    logic [XLEN-1:0] q_pc_q   [FQ_DEPTH];
    logic [31:0]     q_inst_q [FQ_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;

    // NOTE: every signal gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        push     = 1'b0;
        unique case (state_q)
            S_RUN: begin
                imem_req = active_q && (count_q < DEPTH_C);
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_KILL: begin
                if (imem_rvalid) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        if (redirect_en) begin
            imem_req = 1'b0;
            push     = 1'b0;
            pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
            // A response landing in the redirect cycle retires the outstanding fetch,
            // so there is nothing left to kill.
            state_d  = ((state_q != S_RUN) && !imem_rvalid) ? S_KILL : S_RUN;
        end
    end

    assign pop = (count_q != '0) && if_ready && !redirect_en;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            active_q <= 1'b1;
        end
    end

    // NOTE: the queue storage is reset because its head drives if_pc/if_inst, whose reset values are defined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                q_pc_q[i]   <= '0;
                q_inst_q[i] <= NOP;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (redirect_en) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                q_pc_q[wr_ptr_q]   <= req_pc_q;
                q_inst_q[wr_ptr_q] <= imem_rdata;
                wr_ptr_q           <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_pc     = q_pc_q[rd_ptr_q];
    assign if_inst   = q_inst_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (if_ready && !if_valid) bubble_q <= bubble_q + 32'd1;
            if (redirect_en)           flush_q  <= flush_q + 16'd1;
        end
    end

    assign perf_bubble_cnt = bubble_q;
    assign perf_flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a queue-based reference model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk, rst_n;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_inst;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_pc_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FETCH_PERF_EN
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .if_ready    (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: grant sampled mid-cycle, data returned lat cycles later.
    int lat = 1;
    initial begin
        bit          fire, pend;
        int          cnt;
        logic [31:0] a, paddr;
        pend = 0; cnt = 0; paddr = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            fire = imem_req && imem_gnt;
            a    = imem_addr;
            @(posedge clk);
            #1;
            if (fire) begin
                pend  = 1;
                cnt   = lat;
                paddr = a;
            end
            imem_rvalid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst_of(paddr);
                    pend        = 0;
                end
            end
        end
    end

    // Reference model: next fetch address, outstanding fetch (0 none, 1 live, 2 killed),
    // and the decode-bound instruction stream as a queue.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc     = RESET_PC;
    logic [31:0] m_req_pc = '0;
    int          m_out    = 0;
    bit          m_armed  = 0;
    int          m_bub    = 0;
    int          m_flush  = 0;

    initial begin
        bit exp_req;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                m_pc    = RESET_PC;
                m_out   = 0;
                m_armed = 0;
                m_bub   = 0;
                m_flush = 0;
            end else begin
                exp_req = m_armed && (m_out == 0) && (mq.size() < DEPTH) && !redirect_en;
                check("model imem_req", imem_req, exp_req);
                check("model imem_addr", imem_addr, m_pc);
                check("model if_valid", if_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    check("model if_pc", if_pc, mq[0].pc);
                    check("model if_inst", if_inst, mq[0].inst);
                end
                if (if_ready && mq.size() == 0) m_bub++;
                if (redirect_en) begin
                    m_flush++;
                    mq.delete();
                    m_pc  = redirect_pc & ~32'h3;
                    m_out = (m_out != 0 && !imem_rvalid) ? 2 : 0;
                end else begin
                    if (mq.size() != 0 && if_ready) void'(mq.pop_front());
                    if (imem_rvalid && m_out == 1) mq.push_back({m_req_pc, imem_rdata});
                    if (imem_rvalid) m_out = 0;
                    if (exp_req && imem_gnt) begin
                        m_out    = 1;
                        m_req_pc = m_pc;
                        m_pc     = m_pc + 32'd4;
                    end
                end
                m_armed = 1;
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge of the cycle in which a request is granted.
    task automatic wait_grant(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) return;
        end
        timeout(name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_valid) return;
        end
        timeout(name);
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        if_ready    = 1'b0;
        #12;
        check("reset imem_req", imem_req, 1'b0);
        check("reset imem_addr", imem_addr, RESET_PC);
        check("reset if_valid", if_valid, 1'b0);
        check("reset if_pc", if_pc, 32'h0);
        check("reset if_inst", if_inst, 32'h0000_0013);
        drive_edge();
        rst_n    = 1'b1;
        imem_gnt = 1'b1;
        if_ready = 1'b1;

        // 1: streaming fetch, best-case latency
        wait_grant("t1 first grant");
        check("t1 cycle0 addr", imem_addr, 32'h8000_0000);
        check("t1 cycle0 if_valid", if_valid, 1'b0);
        @(negedge clk);
        check("t1 cycle1 if_valid", if_valid, 1'b0);
        check("t1 cycle1 imem_req", imem_req, 1'b0);
        @(negedge clk);
        check("t1 cycle2 if_valid", if_valid, 1'b1);
        check("t1 cycle2 if_pc", if_pc, 32'h8000_0000);
        check("t1 cycle2 if_inst", if_inst, inst_of(32'h8000_0000));
        check("t1 cycle2 imem_req", imem_req, 1'b1);
        check("t1 cycle2 addr", imem_addr, 32'h8000_0004);
        repeat (10) drive_edge();

        // 2: decode stalled, queue fills to depth then requests stop
        redirect_en = 1'b1;
        redirect_pc = 32'h8000_0040;
        if_ready    = 1'b0;
        drive_edge();
        redirect_en = 1'b0;
        repeat (10) drive_edge();
        @(negedge clk);
        check("t2 full imem_req", imem_req, 1'b0);
        check("t2 full addr", imem_addr, 32'h8000_0048);
        check("t2 full if_pc", if_pc, 32'h8000_0040);
        check("t2 full if_inst", if_inst, inst_of(32'h8000_0040));
        drive_edge();
        if_ready = 1'b1;
        @(negedge clk);
        check("t2 pop0 if_pc", if_pc, 32'h8000_0040);
        @(negedge clk);
        check("t2 pop1 if_pc", if_pc, 32'h8000_0044);
        check("t2 resume imem_req", imem_req, 1'b1);
        check("t2 resume addr", imem_addr, 32'h8000_0048);

        // 3: redirect while a fetch is outstanding
        lat = 3;
        wait_grant("t3 grant");
        drive_edge();
        redirect_en = 1'b1;
        redirect_pc = 32'h8000_0100;
        @(negedge clk);
        check("t3 redirect imem_req", imem_req, 1'b0);
        drive_edge();
        redirect_en = 1'b0;
        @(negedge clk);
        check("t3 flushed if_valid", if_valid, 1'b0);
        check("t3 kill imem_req", imem_req, 1'b0);
        wait_grant("t3 regrant");
        check("t3 target addr", imem_addr, 32'h8000_0100);
        wait_valid("t3 valid");
        check("t3 first if_pc", if_pc, 32'h8000_0100);
        check("t3 first if_inst", if_inst, inst_of(32'h8000_0100));

        // 4: unaligned target, then a second redirect while killing
        lat = 4;
        wait_grant("t4 grant");
        drive_edge();
        redirect_en = 1'b1;
        redirect_pc = 32'h8000_0102;
        @(negedge clk);
        check("t4 redirect1 imem_req", imem_req, 1'b0);
        drive_edge();
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("t4 aligned addr", imem_addr, 32'h8000_0100);
        check("t4 redirect2 imem_req", imem_req, 1'b0);
        drive_edge();
        redirect_en = 1'b0;
        @(negedge clk);
        check("t4 kill imem_req", imem_req, 1'b0);
        wait_grant("t4 regrant");
        check("t4 target addr", imem_addr, 32'h0000_0200);
        wait_valid("t4 valid");
        check("t4 first if_pc", if_pc, 32'h0000_0200);
`ifdef FETCH_PERF_EN
        check("perf flush literal", perf_flush_cnt, 16'd4);
        check("perf flush model", perf_flush_cnt, m_flush);
`endif

        // 5: asynchronous reset in the middle of an outstanding fetch
        lat = 3;
        wait_grant("t5 grant");
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        imem_gnt = 1'b0;
        #1;
        check("t5 async imem_req", imem_req, 1'b0);
        check("t5 async addr", imem_addr, RESET_PC);
        check("t5 async if_valid", if_valid, 1'b0);
        check("t5 async if_pc", if_pc, 32'h0);
        check("t5 async if_inst", if_inst, 32'h0000_0013);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) drive_edge();
        @(negedge clk);
        check("t5 late rvalid ignored", if_valid, 1'b0);
        check("t5 restart imem_req", imem_req, 1'b1);
        check("t5 restart addr", imem_addr, RESET_PC);
        drive_edge();
        imem_gnt = 1'b1;
        wait_valid("t5 valid");
        check("t5 first if_pc", if_pc, RESET_PC);
        check("t5 first if_inst", if_inst, inst_of(RESET_PC));

        repeat (6) drive_edge();
        if_ready = 1'b0;
        repeat (3) drive_edge();
`ifdef FETCH_PERF_EN
        check("perf bubble model", perf_bubble_cnt, m_bub);
        check("perf flush after reset", perf_flush_cnt, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
